// File: rtl/rsa_pkg.sv
// Shared types and defaults for the RSA exponentiation controller.
// The state enum lives here so the controller and its surroundings agree on the encoding.
package rsa_pkg;

   localparam int WIDTH_DEF    = 256;
   localparam int EXP_BITS_DEF = 256;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_ISSUE,
      S_MUL_WAIT,
      S_SQR_ISSUE,
      S_SQR_WAIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/rsa_exp_ctrl.sv
// Right-to-left square-and-multiply sequencer for y^d mod n.
// The modular multiplier sits outside this block and is driven through the o_mul_*/i_mul_* handshake.
module rsa_exp_ctrl
   import rsa_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int EXP_BITS = EXP_BITS_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [WIDTH-1:0]    i_base,
   input  logic [EXP_BITS-1:0] i_exp,
   input  logic [WIDTH-1:0]    i_n,
   output logic [WIDTH-1:0]    o_result,
   output logic                o_finish,
   output logic                o_busy,
   output logic                o_mul_start,
   output logic [WIDTH-1:0]    o_mul_a,
   output logic [WIDTH-1:0]    o_mul_b,
   output logic [WIDTH-1:0]    o_mul_n,
   input  logic [WIDTH-1:0]    i_mul_result,
   input  logic                i_mul_finish
);

   localparam int CNT_W = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXP_BITS - 1);

   state_t               r_state;
   state_t               w_nextState;
   logic [WIDTH-1:0]     r_base;
   logic [EXP_BITS-1:0]  r_exp;
   logic [WIDTH-1:0]     r_n;
   logic [WIDTH-1:0]     r_res;
   logic [CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]     r_result;
   logic                 r_mulStart;
   logic [WIDTH-1:0]     r_mulA;
   logic [WIDTH-1:0]     r_mulB;
   logic [WIDTH-1:0]     r_mulN;

   logic                 w_accept;
   logic                 w_issueMul;
   logic                 w_issueSqr;
   logic                 w_mulDone;
   logic                 w_sqrDone;
   logic                 w_toDone;
   logic                 w_finishOk;

   // A finish coinciding with our own start pulse cannot belong to this request.
   assign w_finishOk = i_mul_finish && !r_mulStart;

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_issueMul  = 1'b0;
      w_issueSqr  = 1'b0;
      w_mulDone   = 1'b0;
      w_sqrDone   = 1'b0;
      w_toDone    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_nextState = S_MUL_ISSUE;
            end
         end
         S_MUL_ISSUE: begin
            if (r_exp[r_cnt]) begin
               w_issueMul  = 1'b1;
               w_nextState = S_MUL_WAIT;
            end else begin
               w_nextState = S_SQR_ISSUE;
            end
         end
         S_MUL_WAIT: begin
            if (w_finishOk) begin
               w_mulDone   = 1'b1;
               w_nextState = S_SQR_ISSUE;
            end
         end
         S_SQR_ISSUE: begin
            if (r_cnt == LAST_BIT) begin
               w_toDone    = 1'b1;
               w_nextState = S_DONE;
            end else begin
               w_issueSqr  = 1'b1;
               w_nextState = S_SQR_WAIT;
            end
         end
         S_SQR_WAIT: begin
            if (w_finishOk) begin
               w_sqrDone   = 1'b1;
               w_nextState = S_MUL_ISSUE;
            end
         end
         S_DONE:  w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // The result register loads on entry to S_DONE so o_result is already valid alongside o_finish.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_exp      <= '0;
         r_n        <= '0;
         r_res      <= '0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_mulStart <= 1'b0;
         r_mulA     <= '0;
         r_mulB     <= '0;
         r_mulN     <= '0;
      end else begin
         r_state    <= w_nextState;
         r_mulStart <= w_issueMul | w_issueSqr;
         if (w_accept) begin
            r_base <= i_base;
            r_exp  <= i_exp;
            r_n    <= i_n;
            r_res  <= (i_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_cnt  <= '0;
         end
         if (w_issueMul) begin
            r_mulA <= r_res;
            r_mulB <= r_base;
            r_mulN <= r_n;
         end
         if (w_issueSqr) begin
            r_mulA <= r_base;
            r_mulB <= r_base;
            r_mulN <= r_n;
         end
         if (w_mulDone) begin
            r_res <= i_mul_result;
         end
         if (w_sqrDone) begin
            r_base <= i_mul_result;
            r_cnt  <= r_cnt + CNT_W'(1);
         end
         if (w_toDone) begin
            r_result <= r_res;
         end
      end
   end

   assign o_result    = r_result;
   assign o_finish    = (r_state == S_DONE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_mul_start = r_mulStart;
   assign o_mul_a     = r_mulA;
   assign o_mul_b     = r_mulB;
   assign o_mul_n     = r_mulN;

endmodule
